dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Responder end of the core's data-memory request interface: accepts load/store requests, performs them on an
//  inferred word-wide synchronous RAM, returns responses. Sub-word access: byte-lane store enables, load extension
//  per funct3, misalignment detection. Sits between the MEM stage and data memory; stalls the pipeline via req_ready.
// PARAMETERS
//  ADDR_WIDTH  13             word-address bits; RAM depth = 2**ADDR_WIDTH x 32 bits
//  MMIO_BASE   32'h8000_0000  base of the MMIO window (used only with DMEM_MMIO_EN)
// PORTS
//  clk         in   1   sole clock, rising edge
//  rst         in   1   asynchronous, active-high reset
//  req_valid   in   1   request present
//  req_ready   out  1   request accepted when req_valid && req_ready
//  req_we      in   1   1 = store, 0 = load
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data, right-aligned (rs2)
//  req_funct3  in   3   RV32I width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  rsp_valid   out  1   response present
//  rsp_ready   in   1   response consumed when rsp_valid && rsp_ready
//  rsp_rdata   out  32  load result, extended; 0 for stores and errors
//  rsp_err     out  1   misaligned access, or illegal funct3 (011, 110, 111)
//  led_o       out  8   MMIO LED register (constant 0 without DMEM_MMIO_EN)
// BEHAVIOUR
//  - Reset: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, led_o=0. RAM contents not reset.
//  - FSM: IDLE -> RD (accepted load, no error) -> RSP; IDLE -> RSP (accepted store or error); RSP -> IDLE on rsp_ready.
//  - req_ready=1 only in IDLE. No new request accepted before the previous response is consumed.
//  - Store latency: RAM write on the acceptance edge (cycle N), with byte enables. rsp_valid from N+1.
//  - Load latency: RAM read issued at N; data registered, extended, presented with rsp_valid from N+2.
//  - rsp_valid/rsp_rdata/rsp_err are held stable in RSP until rsp_ready. rsp_ready while not rsp_valid is ignored.
//  - Word index = req_addr[ADDR_WIDTH+1:2]. Upper bits are ignored, so addresses alias and wrap.
//  - Byte lane = req_addr[1:0]. Store enables: B -> 1<<lane; H -> 2'b11<<lane; W -> 4'hF. Data is replicated across lanes.
//  - Load: select byte/half at lane; B/H sign-extend, BU/HU zero-extend, W passes through.
//  - Misaligned: H with addr[0]=1, or W with addr[1:0]!=0. Then: no RAM write, rsp_err=1, rsp_rdata=0, response at N+1.
//  - Illegal funct3: treated like misaligned (err, no write). For stores, the funct3[2] bit is ignored.
//  - rst asserted mid-operation: FSM returns to IDLE immediately and any pending response is dropped.
//    A store already written on a prior edge remains written.
// CONFIGURATION
//  DMEM_MMIO_EN defined: addresses in [MMIO_BASE, MMIO_BASE+8) decode to registers, not RAM. Other addr[31]=1 addresses alias RAM.
//    +0x0: LED register, RW; led_o = reg[7:0], upper bits read 0.
//    +0x4: free-running 32-bit cycle counter, RO; reset 0, wraps; writes ignored.
//    Only W accesses are legal in the window; any other width sets rsp_err. MMIO latency equals RAM latency.
//  Not defined: no decode; every address maps to RAM; led_o tied to 0; counter logic absent.
// STRUCTURE
//  Shared package core_pkg:
//    - F3_LB/F3_LH/F3_LW/F3_LBU/F3_LHU constants
//    - dmem_state_t enum {IDLE, RD, RSP}
//    - MMIO offset constants MMIO_LED_OFS=0, MMIO_CNT_OFS=4
//  Sub-module dmem_lane_align (combinational):
//    - store byte enables and data replication
//    - load lane select and extension
//    - misalign/illegal detect
//  Top level: FSM, RAM array, response registers, optional MMIO.
// TESTING
//  - SW 0xDEADBEEF @0x10, then LW @0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0. Load rsp_valid 2 cycles after acceptance; store rsp 1 cycle after.
//  - After that: SB 0x7F @0x11; LB @0x11 -> 0x0000007F; LB @0x13 -> 0xFFFFFFDE; LHU @0x12 -> 0x0000DEAD;
//    LW @0x10 -> 0xDEAD7FEF.
//  - SW @0x22 -> rsp_err=1, RAM @0x20 unchanged. LH @0x21 -> rsp_err=1, rsp_rdata=0.
//    funct3=011 load -> rsp_err=1.
//  - Hold rsp_ready=0 for 5 cycles -> rsp stable, req_ready=0 throughout; next request accepted the cycle after rsp_ready=1.
//  - Assert rst while in RD -> next cycle rsp_valid=0, req_ready=1. SW issued before the reset reads back intact.
//  - DMEM_MMIO_EN: SW 0xA5 @0x8000_0000 -> led_o=0xA5. Two LW @0x8000_0004 -> second value > first.
//    SB @0x8000_0000 -> rsp_err=1, led_o unchanged.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the core's data-memory path.
//   - RV32I load/store funct3 encodings (B, H, W, BU, HU)
//   - dmem_state_t: responder FSM states
//   - MMIO register byte offsets inside the MMIO window
package core_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    RSP  = 2'd2
  } dmem_state_t;

  localparam logic [2:0] MMIO_LED_OFS = 3'd0;
  localparam logic [2:0] MMIO_CNT_OFS = 3'd4;

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational sub-word handling for the data-memory responder.
// Request side (driven from the live request):
//   req_we, req_lane, req_funct3, req_wdata  -> st_be, st_wdata, acc_err, acc_is_word
// Load side (driven from the registered load context and raw RAM/MMIO word):
//   ld_lane, ld_funct3, ld_word              -> ld_data (selected and extended)
module dmem_lane_align
  import core_pkg::*;
(
  input  logic        req_we,
  input  logic [1:0]  req_lane,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  output logic        acc_err,
  output logic        acc_is_word,
  input  logic [1:0]  ld_lane,
  input  logic [2:0]  ld_funct3,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [1:0]  req_width;
  logic        req_illegal;
  logic        req_misalign;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Request checks and store lane steering. Stores ignore funct3[2], so only
  // width 2'b11 is illegal for them; loads have three illegal encodings.
  always_comb begin
    req_width   = req_funct3[1:0];
    req_illegal = 1'b0;
    if (req_we) begin
      req_illegal = (req_width == 2'b11);
    end else begin
      case (req_funct3)
        F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: req_illegal = 1'b0;
        default:                             req_illegal = 1'b1;
      endcase
    end

    req_misalign = ((req_width == F3_LH[1:0]) && req_lane[0]) ||
                   ((req_width == F3_LW[1:0]) && (req_lane != 2'b00));
    acc_err      = req_illegal | req_misalign;
    acc_is_word  = (req_width == F3_LW[1:0]);

    // Data is replicated across lanes so the byte enables alone pick the target.
    case (req_width)
      2'b00: begin
        st_be    = 4'b0001 << req_lane;
        st_wdata = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        st_be    = 4'b0011 << req_lane;
        st_wdata = {2{req_wdata[15:0]}};
      end
      default: begin
        st_be    = 4'hF;
        st_wdata = req_wdata;
      end
    endcase
  end

  // Load lane select followed by sign or zero extension.
  always_comb begin
    case (ld_lane)
      2'd0:    ld_byte = ld_word[7:0];
      2'd1:    ld_byte = ld_word[15:8];
      2'd2:    ld_byte = ld_word[23:16];
      default: ld_byte = ld_word[31:24];
    endcase
    ld_half = ld_lane[1] ? ld_word[31:16] : ld_word[15:0];

    case (ld_funct3)
      F3_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
      F3_LBU:  ld_data = {24'h0, ld_byte};
      F3_LHU:  ld_data = {16'h0, ld_half};
      default: ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: responder end of the core's data-memory request interface.
// Accepts one load/store at a time, performs it on a word-wide synchronous RAM
// (2**ADDR_WIDTH x 32) and returns a response; holds req_ready low until the
// previous response is consumed.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   req_valid/req_ready           request handshake
//   req_we, req_addr, req_wdata,
//   req_funct3                    request payload (store flag, byte address, rs2, width)
//   rsp_valid/rsp_ready           response handshake
//   rsp_rdata, rsp_err            extended load data (0 for stores/errors), error flag
//   led_o                         MMIO LED register
// Optional feature: define DMEM_MMIO_EN to decode [MMIO_BASE, MMIO_BASE+8) to an
// LED register (+0) and a free-running cycle counter (+4); without it led_o is 0.
module dmem_responder
  import core_pkg::*;
#(
  parameter int          ADDR_WIDTH = 13,
  parameter logic [31:0] MMIO_BASE  = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [7:0]  led_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  dmem_state_t state_q, state_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic [1:0]  ld_lane_q, ld_lane_d;
  logic [2:0]  ld_f3_q, ld_f3_d;

  logic [31:0] mem [0:DEPTH-1];
  logic [31:0] ram_rdata_q;

  logic [ADDR_WIDTH-1:0] word_idx;
  logic        accept;
  logic        mmio_hit;
  logic        req_err;
  logic        ram_we;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic        acc_err;
  logic        acc_is_word;
  logic [31:0] ld_word;
  logic [31:0] ld_data;

  assign word_idx = req_addr[ADDR_WIDTH+1:2];
  assign accept   = (state_q == IDLE) && req_valid;
  assign req_err  = acc_err | (mmio_hit & ~acc_is_word);
  assign ram_we   = accept && req_we && !req_err && !mmio_hit;

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RSP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  dmem_lane_align u_align (
    .req_we      (req_we),
    .req_lane    (req_addr[1:0]),
    .req_funct3  (req_funct3),
    .req_wdata   (req_wdata),
    .st_be       (st_be),
    .st_wdata    (st_wdata),
    .acc_err     (acc_err),
    .acc_is_word (acc_is_word),
    .ld_lane     (ld_lane_q),
    .ld_funct3   (ld_f3_q),
    .ld_word     (ld_word),
    .ld_data     (ld_data)
  );

  // RAM: byte-enabled write and registered read, both on the acceptance edge.
  // No reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (st_be[b]) begin
          mem[word_idx][b*8 +: 8] <= st_wdata[b*8 +: 8];
        end
      end
    end
    if (accept) begin
      ram_rdata_q <= mem[word_idx];
    end
  end

  // Next-state logic. Loads spend one cycle in RD so the registered RAM word
  // can be lane-selected and extended before entering the response register.
  always_comb begin
    state_d     = state_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    ld_lane_d   = ld_lane_q;
    ld_f3_d     = ld_f3_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          ld_lane_d = req_addr[1:0];
          ld_f3_d   = req_funct3;
          if (req_err) begin
            state_d     = RSP;
            rsp_rdata_d = 32'h0;
            rsp_err_d   = 1'b1;
          end else if (req_we) begin
            state_d     = RSP;
            rsp_rdata_d = 32'h0;
            rsp_err_d   = 1'b0;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: begin
        state_d     = RSP;
        rsp_rdata_d = ld_data;
        rsp_err_d   = 1'b0;
      end
      RSP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
      ld_lane_q   <= 2'b00;
      ld_f3_q     <= F3_LW;
    end else begin
      state_q     <= state_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      ld_lane_q   <= ld_lane_d;
      ld_f3_q     <= ld_f3_d;
    end
  end

`ifdef DMEM_MMIO_EN
  logic [7:0]  led_q, led_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] mmio_rdata_q, mmio_rdata_d;
  logic        ld_mmio_q, ld_mmio_d;

  // Only the 8-byte window decodes to registers; other high addresses alias RAM.
  assign mmio_hit = (req_addr[31:3] == MMIO_BASE[31:3]);
  assign led_o    = led_q;
  assign ld_word  = ld_mmio_q ? mmio_rdata_q : ram_rdata_q;

  // Register reads are sampled on the acceptance edge like a RAM read, so the
  // MMIO path has the same latency through RD.
  always_comb begin
    cnt_d        = cnt_q + 32'd1;
    led_d        = led_q;
    mmio_rdata_d = mmio_rdata_q;
    ld_mmio_d    = ld_mmio_q;
    if (accept) begin
      ld_mmio_d = mmio_hit;
      if (mmio_hit && !req_err) begin
        if (req_we) begin
          if (req_addr[2:0] == MMIO_LED_OFS) begin
            led_d = req_wdata[7:0];
          end
        end else begin
          mmio_rdata_d = (req_addr[2:0] == MMIO_CNT_OFS) ? cnt_q : {24'h0, led_q};
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q        <= 8'h0;
      cnt_q        <= 32'h0;
      mmio_rdata_q <= 32'h0;
      ld_mmio_q    <= 1'b0;
    end else begin
      led_q        <= led_d;
      cnt_q        <= cnt_d;
      mmio_rdata_q <= mmio_rdata_d;
      ld_mmio_q    <= ld_mmio_d;
    end
  end
`else
  logic unused_cfg;

  // Every address maps to RAM; the upper address bits simply alias.
  assign mmio_hit   = 1'b0;
  assign led_o      = 8'h0;
  assign ld_word    = ram_rdata_q;
  assign unused_cfg = ^{req_addr[31:ADDR_WIDTH+2], MMIO_BASE};
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed self-checking bench for dmem_responder.
// Each request is driven through applyStimulus, which also checks the response
// latency, data and error flag against hand-computed values via checkOutput.
// Build with DMEM_MMIO_EN defined to exercise the MMIO window.
module tb_dmem_responder;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [7:0]  led_o;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] last_rdata;

  dmem_responder dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_funct3 (req_funct3),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .led_o      (led_o)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request from IDLE, measure latency to rsp_valid, check the
  // response, then consume it. Stores and errors answer after one edge,
  // successful loads after two.
  task automatic applyStimulus(input string tag, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [2:0] f3,
                               input logic [31:0] exp_rdata, input logic exp_err,
                               input bit chk_data = 1'b1);
    int lat;
    int exp_lat;
    exp_lat = (we || exp_err) ? 1 : 2;
    checkOutput({tag, ".ready"}, {31'h0, req_ready}, 32'h1);
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = addr;
    req_wdata  = wdata;
    req_funct3 = f3;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 8) begin
      @(posedge clk);
      #1;
      lat++;
    end
    last_rdata = rsp_rdata;
    checkOutput({tag, ".lat"}, lat, exp_lat);
    checkOutput({tag, ".err"}, {31'h0, rsp_err}, {31'h0, exp_err});
    if (chk_data) begin
      checkOutput({tag, ".rdata"}, rsp_rdata, exp_rdata);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] cnt_first;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    req_funct3 = F3_LW;
    rsp_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    $display("[TB] reset state");
    checkOutput("rst.req_ready", {31'h0, req_ready}, 32'h1);
    checkOutput("rst.rsp_valid", {31'h0, rsp_valid}, 32'h0);
    checkOutput("rst.rsp_rdata", rsp_rdata, 32'h0);
    checkOutput("rst.rsp_err",   {31'h0, rsp_err}, 32'h0);
    checkOutput("rst.led_o",     {24'h0, led_o}, 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] word and sub-word access");
    applyStimulus("sw10",   1'b1, 32'h10, 32'hDEADBEEF, F3_LW, 32'h0, 1'b0);
    applyStimulus("lw10",   1'b0, 32'h10, 32'h0, F3_LW,  32'hDEADBEEF, 1'b0);
    applyStimulus("sb11",   1'b1, 32'h11, 32'h0000007F, F3_LB, 32'h0, 1'b0);
    applyStimulus("lb11",   1'b0, 32'h11, 32'h0, F3_LB,  32'h0000007F, 1'b0);
    applyStimulus("lb13",   1'b0, 32'h13, 32'h0, F3_LB,  32'hFFFFFFDE, 1'b0);
    applyStimulus("lhu12",  1'b0, 32'h12, 32'h0, F3_LHU, 32'h0000DEAD, 1'b0);
    applyStimulus("lh12",   1'b0, 32'h12, 32'h0, F3_LH,  32'hFFFFDEAD, 1'b0);
    applyStimulus("lbu13",  1'b0, 32'h13, 32'h0, F3_LBU, 32'h000000DE, 1'b0);
    applyStimulus("lb10",   1'b0, 32'h10, 32'h0, F3_LB,  32'hFFFFFFEF, 1'b0);
    applyStimulus("lw10b",  1'b0, 32'h10, 32'h0, F3_LW,  32'hDEAD7FEF, 1'b0);
    applyStimulus("sw14",   1'b1, 32'h14, 32'h11223344, F3_LW, 32'h0, 1'b0);
    applyStimulus("sh16",   1'b1, 32'h16, 32'hFFFFCAFE, F3_LH, 32'h0, 1'b0);
    applyStimulus("lw14",   1'b0, 32'h14, 32'h0, F3_LW,  32'hCAFE3344, 1'b0);
    applyStimulus("lhu14",  1'b0, 32'h14, 32'h0, F3_LHU, 32'h00003344, 1'b0);
    applyStimulus("lb16",   1'b0, 32'h16, 32'h0, F3_LB,  32'hFFFFFFFE, 1'b0);
    applyStimulus("alias",  1'b0, 32'h8010, 32'h0, F3_LW, 32'hDEAD7FEF, 1'b0);

    $display("[TB] errors and illegal encodings");
    applyStimulus("sw20",   1'b1, 32'h20, 32'h12345678, F3_LW, 32'h0, 1'b0);
    applyStimulus("sw22",   1'b1, 32'h22, 32'hFFFFFFFF, F3_LW, 32'h0, 1'b1);
    applyStimulus("lw20",   1'b0, 32'h20, 32'h0, F3_LW,  32'h12345678, 1'b0);
    applyStimulus("lh21",   1'b0, 32'h21, 32'h0, F3_LH,  32'h0, 1'b1);
    applyStimulus("ld011",  1'b0, 32'h20, 32'h0, 3'b011, 32'h0, 1'b1);
    applyStimulus("ld110",  1'b0, 32'h20, 32'h0, 3'b110, 32'h0, 1'b1);
    applyStimulus("st011",  1'b1, 32'h20, 32'h0, 3'b011, 32'h0, 1'b1);
    applyStimulus("st110",  1'b1, 32'h20, 32'h0BADF00D, 3'b110, 32'h0, 1'b0);
    applyStimulus("lw20b",  1'b0, 32'h20, 32'h0, F3_LW,  32'h0BADF00D, 1'b0);

    $display("[TB] response backpressure");
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_addr   = 32'h10;
    req_funct3 = F3_LW;
    @(posedge clk);
    #1;
    req_addr = 32'h14;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      checkOutput("hold.rsp_valid", {31'h0, rsp_valid}, 32'h1);
      checkOutput("hold.rsp_rdata", rsp_rdata, 32'hDEAD7FEF);
      checkOutput("hold.req_ready", {31'h0, req_ready}, 32'h0);
      @(posedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    checkOutput("hold.idle_ready", {31'h0, req_ready}, 32'h1);
    checkOutput("hold.idle_valid", {31'h0, rsp_valid}, 32'h0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    checkOutput("hold.accepted", {31'h0, req_ready}, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("hold.next_valid", {31'h0, rsp_valid}, 32'h1);
    checkOutput("hold.next_rdata", rsp_rdata, 32'hCAFE3344);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;

    $display("[TB] reset during load");
    applyStimulus("sw30", 1'b1, 32'h30, 32'h600DCAFE, F3_LW, 32'h0, 1'b0);
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_addr   = 32'h30;
    req_funct3 = F3_LW;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst       = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rstrd.rsp_valid", {31'h0, rsp_valid}, 32'h0);
    checkOutput("rstrd.req_ready", {31'h0, req_ready}, 32'h1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus("lw30", 1'b0, 32'h30, 32'h0, F3_LW, 32'h600DCAFE, 1'b0);

`ifdef DMEM_MMIO_EN
    $display("[TB] MMIO window");
    applyStimulus("mmio.sw_led", 1'b1, 32'h8000_0000, 32'h000000A5, F3_LW, 32'h0, 1'b0);
    checkOutput("mmio.led_o", {24'h0, led_o}, 32'h000000A5);
    applyStimulus("mmio.lw_led", 1'b0, 32'h8000_0000, 32'h0, F3_LW, 32'h000000A5, 1'b0);
    applyStimulus("mmio.cnt1", 1'b0, 32'h8000_0004, 32'h0, F3_LW, 32'h0, 1'b0, 1'b0);
    cnt_first = last_rdata;
    applyStimulus("mmio.cnt2", 1'b0, 32'h8000_0004, 32'h0, F3_LW, 32'h0, 1'b0, 1'b0);
    checkOutput("mmio.cnt_incr", {31'h0, (last_rdata > cnt_first)}, 32'h1);
    applyStimulus("mmio.sb_led", 1'b1, 32'h8000_0000, 32'h0000003C, F3_LB, 32'h0, 1'b1);
    checkOutput("mmio.led_keep", {24'h0, led_o}, 32'h000000A5);
`else
    $display("[TB] high addresses alias RAM");
    cnt_first = 32'h0;
    applyStimulus("nommio.sw", 1'b1, 32'h8000_0000, 32'h000000A5, F3_LW, 32'h0, 1'b0);
    checkOutput("nommio.led_o", {24'h0, led_o} | cnt_first, 32'h0);
    applyStimulus("nommio.lw0", 1'b0, 32'h0, 32'h0, F3_LW, 32'h000000A5, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
